vector_processor_seq: RTL and testbench
=======================================

// Module: vector_processor_seq
// PURPOSE
//   Parametrised, multi-cycle successor to the single-cycle vector processor. Holds four
//   vector registers A1..A4 (LANES x DATA_W) and a word-addressed local memory.
//   Executes LOAD/STORE/ADD/MUL lane-serially, LANES_PER_CYCLE lanes per clock.
//   Uses a start/ready/busy/done handshake so a controller can sequence it.
// PARAMETERS
//   LANES            16   lanes per vector register
//   DATA_W           32   bits per lane (signed two's complement)
//   MEM_DEPTH        512  memory words of DATA_W
//   ADDR_W           9    memory address width; must equal clog2(MEM_DEPTH)
//   LANES_PER_CYCLE  4    lanes processed per EXEC cycle; must divide LANES (G = LANES/LANES_PER_CYCLE)
// PORTS
//   clk           in   1        clock, rising edge
//   rst           in   1        asynchronous reset, active-high
//   start         in   1        request; accepted only when ready=1
//   instruction   in   2        00 LOAD, 01 STORE, 10 ADD, 11 MUL; sampled on accept
//   mem_addr      in   ADDR_W   base word address for LOAD/STORE; sampled on accept
//   reg_select    in   2        00 A1, 01 A2, 10 A3, 11 A4; LOAD/STORE target; sampled on accept
//   ready         out  1        high in IDLE
//   busy          out  1        high in EXEC
//   done          out  1        one-cycle pulse when the op completes
//   out_of_bound  out  1        valid with done; held until the next accepted start
// BEHAVIOUR
//   - Reset: state IDLE; ready=1, busy=0, done=0, out_of_bound=0; A1..A4 cleared to 0.
//     Memory is not cleared and keeps its contents; the bench preloads it hierarchically.
//     When rst is asserted mid-op, the op is abandoned and no further lane writes occur.
//   - FSM: IDLE --start--> EXEC (or DONE if out of bound); EXEC stays for G cycles, one
//     lane group per cycle (group k = lanes k*LPC..k*LPC+LPC-1, ascending); EXEC -> DONE;
//     DONE (done=1 for 1 cycle) -> IDLE.
//   - Latency: start accepted at edge 0; groups written on edges 1..G; done high during
//     the cycle after edge G; ready again one cycle later. Defaults: done 5 cycles after accept.
//   - start while ready=0 is ignored; operands are not re-sampled.
//   - Bound check (LOAD/STORE only), at accept: OOB if mem_addr > MEM_DEPTH-LANES.
//     OOB -> straight to DONE with out_of_bound=1, no register or memory write.
//     ADD/MUL never flag OOB.
//   - LOAD: Rsel lane i <= mem[mem_addr+i].  STORE: mem[mem_addr+i] <= Rsel lane i.
//   - ADD: per lane s = A1[i]+A2[i] (signed). A3[i] <= s[DATA_W-1:0].
//     A4[i] <= {0..., ovf}, where ovf = signed overflow (operand signs equal, result sign differs).
//   - MUL: per lane p = A1[i]*A2[i], 2*DATA_W signed. A3[i] <= p low half; A4[i] <= p high half.
//   - A1/A2 are only read during ADD/MUL; all groups of an op see the same source values.
// CONFIGURATION
//   VP_SAT_EN defined: on ADD with ovf=1, A3[i] saturates to 0x7FF..F (positive overflow)
//     or 0x800..0 (negative overflow); A4 is unchanged in meaning. Latency is unchanged.
//   VP_SAT_EN undefined: ADD wraps, as above. All other ops are identical either way.
// TESTING (defaults)
//   1 mem[0..15]=1..16, mem[16..31]=2,4..32; LOAD 0->A1, LOAD 16->A2, ADD
//     -> A3[i]=3(i+1), A4=0; done exactly 5 cycles after each accept.
//   2 Same operands, MUL -> A3[i]=2(i+1)^2, A4[i]=0.
//   3 A1 lanes=7FFFFFFF, A2 lanes=00000001, ADD -> A3=80000000 (sat: 7FFFFFFF), A4=00000001;
//     A1=80000000, A2=FFFFFFFF, MUL -> A3=80000000, A4=00000000.
//   4 LOAD mem_addr=500 -> out_of_bound=1 with done 1 cycle after accept, A1 unchanged;
//     STORE 500 -> OOB, memory unchanged; LOAD 496 -> out_of_bound=0.
//   5 STORE A3 to 100 -> mem[100+i]=A3[i]; a second start pulsed during busy is ignored.
//   6 rst asserted during EXEC of a LOAD -> same cycle busy=done=out_of_bound=0, ready=1,
//     A1..A4=0; memory intact; next op executes normally.

Source files
------------

// File: rtl/vector_processor_seq_if.sv
// Controller-facing handshake and operand bundle of vector_processor_seq.
// The master drives the request side, and the slave (the processor) drives the status side.
interface vector_processor_seq_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [1:0]        instruction;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        reg_select;
    logic              ready;
    logic              busy;
    logic              done;
    logic              out_of_bound;

    modport master (
        output start, instruction, mem_addr, reg_select,
        input  ready, busy, done, out_of_bound
    );

    modport slave (
        input  start, instruction, mem_addr, reg_select,
        output ready, busy, done, out_of_bound
    );
endinterface

// File: rtl/vector_processor_seq.sv
// Lane-serial vector processor: LOAD/STORE/ADD/MUL on four vector registers plus a local memory.
// Optional feature macro VP_SAT_EN: when defined, ADD saturates on signed overflow instead of wrapping.
module vector_processor_seq #(
    parameter int LANES           = 16,
    parameter int DATA_W          = 32,
    parameter int MEM_DEPTH       = 512,
    parameter int ADDR_W          = 9,
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_processor_seq_if.slave bus
);
    localparam int G      = LANES / LANES_PER_CYCLE;
    localparam int GRP_W  = (G > 1) ? $clog2(G) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_MUL   = 2'b11;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [GRP_W-1:0]  r_grp;
    logic [1:0]        r_op;
    logic [1:0]        r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic              r_oob;

    logic [DATA_W-1:0] r_vreg [4][LANES];
    logic [DATA_W-1:0] r_mem  [MEM_DEPTH];

    logic              w_accept;
    logic              w_oob_in;
    logic              w_exec;
    logic [LANE_W-1:0] w_lane    [LANES_PER_CYCLE];
    logic [ADDR_W-1:0] w_mem_idx [LANES_PER_CYCLE];
    logic [DATA_W-1:0] w_ld      [LANES_PER_CYCLE];
    logic [DATA_W-1:0] w_st      [LANES_PER_CYCLE];
    logic [DATA_W-1:0] w_res3    [LANES_PER_CYCLE];
    logic [DATA_W-1:0] w_res4    [LANES_PER_CYCLE];

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_exec   = (r_state == S_EXEC);
    // Only memory ops can run off the end; the whole vector must fit below MEM_DEPTH.
    assign w_oob_in = !bus.instruction[1] &&
                      (32'(bus.mem_addr) > 32'(MEM_DEPTH - LANES));

    generate
        for (genvar gi = 0; gi < LANES_PER_CYCLE; gi++) begin : g_lane
            logic [DATA_W-1:0]   w_a1;
            logic [DATA_W-1:0]   w_a2;
            logic [DATA_W-1:0]   w_sum;
            logic [DATA_W-1:0]   w_add;
            logic [2*DATA_W-1:0] w_prod;
            logic                w_ovf;

            assign w_lane[gi]    = LANE_W'(r_grp) * LANE_W'(LANES_PER_CYCLE) + LANE_W'(gi);
            assign w_mem_idx[gi] = r_addr + ADDR_W'(w_lane[gi]);
            assign w_ld[gi]      = r_mem[w_mem_idx[gi]];
            assign w_st[gi]      = r_vreg[r_sel][w_lane[gi]];

            assign w_a1  = r_vreg[0][w_lane[gi]];
            assign w_a2  = r_vreg[1][w_lane[gi]];
            assign w_sum = w_a1 + w_a2;
            assign w_ovf = (w_a1[DATA_W-1] == w_a2[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != w_a1[DATA_W-1]);
            // Sign-extended operands make the low 2*DATA_W bits of the product the signed result.
            assign w_prod = {{DATA_W{w_a1[DATA_W-1]}}, w_a1} *
                            {{DATA_W{w_a2[DATA_W-1]}}, w_a2};
`ifdef VP_SAT_EN
            assign w_add = !w_ovf          ? w_sum :
                           w_a1[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                            {1'b0, {(DATA_W-1){1'b1}}};
`else
            assign w_add = w_sum;
`endif
            assign w_res3[gi] = (r_op == OP_MUL) ? w_prod[DATA_W-1:0] : w_add;
            assign w_res4[gi] = (r_op == OP_MUL) ? w_prod[2*DATA_W-1:DATA_W] : DATA_W'(w_ovf);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = w_oob_in ? S_DONE : S_EXEC;
            S_EXEC:  if (r_grp == GRP_W'(G - 1)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (r_state)
            S_IDLE:  bus.ready = 1'b1;
            S_EXEC:  bus.busy  = 1'b1;
            S_DONE:  bus.done  = 1'b1;
            default: ;
        endcase
    end

    assign bus.out_of_bound = r_oob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grp  <= '0;
            r_op   <= OP_LOAD;
            r_sel  <= '0;
            r_addr <= '0;
            r_oob  <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_vreg[r][l] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                r_op   <= bus.instruction;
                r_sel  <= bus.reg_select;
                r_addr <= bus.mem_addr;
                r_oob  <= w_oob_in;
                r_grp  <= '0;
            end else if (w_exec) begin
                r_grp <= r_grp + 1'b1;
            end
            if (w_exec) begin
                for (int j = 0; j < LANES_PER_CYCLE; j++) begin
                    if (r_op == OP_LOAD) begin
                        r_vreg[r_sel][w_lane[j]] <= w_ld[j];
                    end else if (r_op[1]) begin
                        r_vreg[2][w_lane[j]] <= w_res3[j];
                        r_vreg[3][w_lane[j]] <= w_res4[j];
                    end
                end
            end
        end
    end

    // Memory is never reset; an async reset forces IDLE, which blocks further writes.
    always_ff @(posedge clk) begin
        if (w_exec && (r_op == OP_STORE)) begin
            for (int j = 0; j < LANES_PER_CYCLE; j++) begin
                r_mem[w_mem_idx[j]] <= w_st[j];
            end
        end
    end
endmodule

// File: tb/tb_vector_processor_seq.sv
// Randomized and directed bench for vector_processor_seq.
// Checks every op against an array-based reference model; VP_SAT_EN selects the saturating ADD model.
module tb_vector_processor_seq;
    localparam int LANES     = 16;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 512;
    localparam int ADDR_W    = 9;
    localparam int LPC       = 4;
    localparam int G         = LANES / LPC;
    localparam longint MAXV  = 64'sd2147483647;
    localparam longint MINV  = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] m_mem [MEM_DEPTH];
    logic [31:0] m_reg [4][LANES];

    vector_processor_seq_if #(.ADDR_W(ADDR_W)) bus ();

    vector_processor_seq #(
        .LANES(LANES), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
        .ADDR_W(ADDR_W), .LANES_PER_CYCLE(LPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs();
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < LANES; l++)
                check($sformatf("A%0d[%0d]", r + 1, l), dut.r_vreg[r][l], m_reg[r][l]);
    endtask

    task automatic check_mem();
        for (int a = 0; a < MEM_DEPTH; a++)
            check($sformatf("mem[%0d]", a), dut.r_mem[a], m_mem[a]);
    endtask

    task automatic poke(input int addr, input logic [31:0] val);
        dut.r_mem[addr] = val;
        m_mem[addr]     = val;
    endtask

    // Reference: whole-vector semantics with wide integer arithmetic.
    task automatic model_apply(input logic [1:0] ins, input int addr, input logic [1:0] sel,
                               output bit oob);
        longint a, b, s, p;
        bit     ovf;
        oob = (ins < 2) && (addr + LANES > MEM_DEPTH);
        if (oob) return;
        for (int i = 0; i < LANES; i++) begin
            a = longint'($signed(m_reg[0][i]));
            b = longint'($signed(m_reg[1][i]));
            case (ins)
                2'd0: m_reg[sel][i] = m_mem[addr + i];
                2'd1: m_mem[addr + i] = m_reg[sel][i];
                2'd2: begin
                    s   = a + b;
                    ovf = (s > MAXV) || (s < MINV);
`ifdef VP_SAT_EN
                    m_reg[2][i] = !ovf ? s[31:0] : (s > 0 ? 32'h7FFF_FFFF : 32'h8000_0000);
`else
                    m_reg[2][i] = s[31:0];
`endif
                    m_reg[3][i] = {31'd0, ovf};
                end
                default: begin
                    p = a * b;
                    m_reg[2][i] = p[31:0];
                    m_reg[3][i] = p[63:32];
                end
            endcase
        end
    endtask

    task automatic do_op(input logic [1:0] ins, input int addr, input logic [1:0] sel,
                         input bit extra);
        bit exp_oob;
        int lat;
        @(negedge clk);
        check("ready_before", bus.ready, 1);
        bus.start       = 1'b1;
        bus.instruction = ins;
        bus.mem_addr    = ADDR_W'(addr);
        bus.reg_select  = sel;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 4 * G) begin
            if (extra && lat == 2) begin
                check("busy_during_exec", bus.busy, 1);
                bus.start       = 1'b1;
                bus.instruction = ~ins;
                bus.reg_select  = ~sel;
                bus.mem_addr    = '0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        model_apply(ins, addr, sel, exp_oob);
        check("done", bus.done, 1);
        check("latency", lat, exp_oob ? 1 : G + 1);
        check("out_of_bound", bus.out_of_bound, exp_oob);
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        check("ready_after", bus.ready, 1);
        check("oob_held", bus.out_of_bound, exp_oob);
        check_regs();
        if (ins == 2'd1) check_mem();
        $display("[TB] op=%0d addr=%0d sel=%0d oob=%0b latency=%0d", ins, addr, sel,
                 bus.out_of_bound, lat);
    endtask

    initial begin
        bit [1:0] r_ins;
        int       r_addr;
        bus.start       = 1'b0;
        bus.instruction = 2'b00;
        bus.mem_addr    = '0;
        bus.reg_select  = 2'b00;
        for (int a = 0; a < MEM_DEPTH; a++) poke(a, $urandom);
        for (int i = 0; i < LANES; i++) begin
            poke(i, 32'(i + 1));
            poke(16 + i, 32'(2 * (i + 1)));
        end
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < LANES; l++) m_reg[r][l] = '0;

        #1;
        check("rst_ready", bus.ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_oob", bus.out_of_bound, 0);
        check_regs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");

        // Small integer vectors: ADD then MUL.
        do_op(2'd0, 0, 2'd0, 1'b0);
        do_op(2'd0, 16, 2'd1, 1'b0);
        do_op(2'd2, 0, 2'd0, 1'b0);
        check("t1_add_a3_5", dut.r_vreg[2][5], 18);
        check("t1_add_a4_5", dut.r_vreg[3][5], 0);
        do_op(2'd3, 0, 2'd0, 1'b0);
        check("t2_mul_a3_3", dut.r_vreg[2][3], 32);
        check("t2_mul_a4_15", dut.r_vreg[3][15], 0);

        // Overflow corners.
        for (int i = 0; i < LANES; i++) begin
            poke(200 + i, 32'h7FFF_FFFF);
            poke(216 + i, 32'h0000_0001);
            poke(240 + i, 32'h8000_0000);
            poke(256 + i, 32'hFFFF_FFFF);
        end
        do_op(2'd0, 200, 2'd0, 1'b0);
        do_op(2'd0, 216, 2'd1, 1'b0);
        do_op(2'd2, 0, 2'd0, 1'b0);
`ifdef VP_SAT_EN
        check("t3_add_a3", dut.r_vreg[2][0], 32'h7FFF_FFFF);
`else
        check("t3_add_a3", dut.r_vreg[2][0], 32'h8000_0000);
`endif
        check("t3_add_a4", dut.r_vreg[3][0], 1);
        do_op(2'd0, 240, 2'd0, 1'b0);
        do_op(2'd0, 256, 2'd1, 1'b0);
        do_op(2'd3, 0, 2'd0, 1'b0);
        check("t3_mul_a3", dut.r_vreg[2][7], 32'h8000_0000);
        check("t3_mul_a4", dut.r_vreg[3][7], 0);

        // Address bound: 496 is the last legal base.
        do_op(2'd0, 500, 2'd0, 1'b0);
        do_op(2'd1, 500, 2'd2, 1'b0);
        do_op(2'd0, 496, 2'd3, 1'b0);
        do_op(2'd1, 497, 2'd3, 1'b0);

        // STORE with a stray start during busy.
        do_op(2'd1, 100, 2'd2, 1'b1);
        check("t5_mem100", dut.r_mem[100], m_reg[2][0]);

        // Reset in the middle of a LOAD.
        @(negedge clk);
        bus.start = 1'b1; bus.instruction = 2'd0; bus.mem_addr = ADDR_W'(32); bus.reg_select = 2'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("t6_busy_mid", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("t6_ready", bus.ready, 1);
        check("t6_busy", bus.busy, 0);
        check("t6_done", bus.done, 0);
        check("t6_oob", bus.out_of_bound, 0);
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < LANES; l++) m_reg[r][l] = '0;
        check_regs();
        @(negedge clk);
        rst = 1'b0;
        check_mem();
        $display("[TB] reset during LOAD applied");
        do_op(2'd0, 32, 2'd0, 1'b0);

        // Random traffic, mostly in bounds.
        for (int n = 0; n < 40; n++) begin
            r_ins  = 2'($urandom_range(0, 3));
            r_addr = ($urandom_range(0, 7) == 0) ? $urandom_range(497, MEM_DEPTH - 1)
                                                 : $urandom_range(0, MEM_DEPTH - LANES);
            do_op(r_ins, r_addr, 2'($urandom_range(0, 3)), n % 5 == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
